// File: rtl/seg7_capture.sv
// Receive side of a two-digit multiplexed seven-segment display: recovers the
// tens/units BCD digits from the active-low segment bus and strobes VALID on each update.
module seg7_capture #(
    parameter int STABLE_CNT = 4
) (
    input  logic       CLOCK_50,
    input  logic       RST_N,
    input  logic [6:0] SEG,
    input  logic [1:0] DIG,
    output logic [3:0] BCD1,
    output logic [3:0] BCD0,
    output logic       VALID,
    output logic       ERR
);

    localparam int CW = $clog2(STABLE_CNT + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_CNT);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CNT - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    // Returns {legal, value}; anything outside the ten digit glyphs is illegal.
    function automatic logic [4:0] decode(input logic [6:0] pattern);
        logic [4:0] result;
        case (pattern)
            7'b1000000: result = 5'h10;
            7'b1111001: result = 5'h11;
            7'b0100100: result = 5'h12;
            7'b0110000: result = 5'h13;
            7'b0011001: result = 5'h14;
            7'b0010010: result = 5'h15;
            7'b0000010: result = 5'h16;
            7'b1111000: result = 5'h17;
            7'b0000000: result = 5'h18;
            7'b0010000: result = 5'h19;
            default:    result = 5'h00;
        endcase
        return result;
    endfunction

    logic [6:0] seg_meta, sseg;
    logic [1:0] dig_meta, sdig;

    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            seg_meta <= 7'h7F;
            sseg     <= 7'h7F;
            dig_meta <= 2'b00;
            sdig     <= 2'b00;
        end else begin
            seg_meta <= SEG;
            sseg     <= seg_meta;
            dig_meta <= DIG;
            sdig     <= dig_meta;
        end
    end

    logic [1:0] sel;
    logic [4:0] dec;

    assign sel = {sdig == 2'b10, sdig == 2'b01};
    assign dec = decode(sseg);

    // Index 0 is the units channel, index 1 the tens channel.
    logic [6:0]    sample [2];
    logic [CW-1:0] cnt    [2];
    logic [3:0]    cand   [2];
    logic [1:0]    seen;
    logic [1:0]    new_evt;

    // Channel state persists across scan visits, so stability is counted over the
    // samples a channel actually receives, not over wall-clock cycles.
    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < 2; i++) begin
                sample[i] <= 7'h7F;
                cnt[i]    <= '0;
                cand[i]   <= '0;
            end
            seen    <= '0;
            new_evt <= '0;
            ERR     <= 1'b0;
        end else begin
            new_evt <= '0;
            for (int i = 0; i < 2; i++) begin
                if (sel[i]) begin
                    if (sseg != sample[i]) begin
                        sample[i] <= sseg;
                        cnt[i]    <= CNT_ONE;
                    end else if (cnt[i] < CNT_MAX) begin
                        cnt[i] <= cnt[i] + CNT_ONE;
                        if (cnt[i] == CNT_LAST) begin
                            if (dec[4]) begin
                                cand[i]    <= dec[3:0];
                                seen[i]    <= 1'b1;
                                new_evt[i] <= 1'b1;
                            end else begin
                                ERR <= 1'b1;
                            end
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            BCD1  <= '0;
            BCD0  <= '0;
            VALID <= 1'b0;
        end else begin
            VALID <= 1'b0;
            if ((|new_evt) && (&seen)) begin
                BCD1  <= cand[1];
                BCD0  <= cand[0];
                VALID <= 1'b1;
            end
        end
    end

endmodule
